// File: rtl/wb_regfile_pkg.sv
// Shared constants and write-back bundle layout for the 8-bit pipeline write-back stage.
// The same field positions are used by the memory/IO producer and by wb_regfile.
package wb_regfile_pkg;

    localparam int DATA_W       = 8;
    localparam int ADDR_W       = 3;
    localparam int NREGS        = 2 ** ADDR_W;
    localparam int MAX_INFLIGHT = 3;
    localparam int CNT_W        = 2;
    localparam int WB_W         = DATA_W + ADDR_W + 1;

    localparam int REG_W        = DATA_W;
    localparam int REG_ADDR_W   = ADDR_W;
    localparam int WB_DATA_HI   = 11;
    localparam int WB_DATA_LO   = 4;
    localparam int WB_ADDR_HI   = 3;
    localparam int WB_ADDR_LO   = 1;
    localparam int WB_WE        = 0;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] addr;
        logic              we;
    } wb_bundle_t;

    function automatic wb_bundle_t wb_unpack(input logic [WB_W-1:0] bundle);
        wb_bundle_t b;
        b.data = bundle[WB_DATA_HI:WB_DATA_LO];
        b.addr = bundle[WB_ADDR_HI:WB_ADDR_LO];
        b.we   = bundle[WB_WE];
        return b;
    endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Per-register in-flight write counters, decode hazard detection and sticky
// over/underflow error flag for the write-back register file.
module wb_scoreboard
    import wb_regfile_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rd,
    input  logic              dec_valid,
    input  logic [ADDR_W-1:0] dec_addr,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    input  logic              use_a,
    input  logic              use_b,
    input  logic              byp_hit_a,
    input  logic              byp_hit_b,
    output logic              hz_a,
    output logic              hz_b,
    output logic              err
);

    logic [CNT_W-1:0] pend_q [NREGS];
    logic [CNT_W-1:0] pend_d [NREGS];
    logic             err_q;
    logic             err_d;
    logic             inc_s;
    logic             inc_r_s;
    logic             dec_r_s;

    // Hazard: a bypass hit covers exactly one outstanding write.
    always_comb begin
        hz_a  = use_a & (pend_q[rd_addr_a] > {{(CNT_W-1){1'b0}}, byp_hit_a});
        hz_b  = use_b & (pend_q[rd_addr_b] > {{(CNT_W-1){1'b0}}, byp_hit_b});
        inc_s = issue_valid & ~(hz_a | hz_b);
    end

    // Counter next-state with saturation and error capture
    always_comb begin
        err_d   = err_q;
        inc_r_s = 1'b0;
        dec_r_s = 1'b0;
        for (int r = 0; r < NREGS; r++) begin
            pend_d[r] = pend_q[r];
            inc_r_s   = inc_s & (issue_rd == ADDR_W'(r));
            dec_r_s   = dec_valid & (dec_addr == ADDR_W'(r));
            if (inc_r_s && !dec_r_s) begin
                if (pend_q[r] == CNT_W'(MAX_INFLIGHT)) begin
                    err_d = 1'b1;
                end else begin
                    pend_d[r] = pend_q[r] + CNT_W'(1);
                end
            end else if (dec_r_s && !inc_r_s) begin
                if (pend_q[r] == CNT_W'(0)) begin
                    err_d = 1'b1;
                end else begin
                    pend_d[r] = pend_q[r] - CNT_W'(1);
                end
            end else begin
                pend_d[r] = pend_q[r];
            end
        end
    end

    // Counter and error state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                pend_q[r] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                pend_q[r] <= pend_d[r];
            end
            err_q <= err_d;
        end
    end

    assign err = err_q;

endmodule

// File: rtl/wb_regfile.sv
// Write-back register file: 8 x 8-bit array, two read ports and decode stall.
// Define WB_BYPASS_EN to forward same-cycle commit data and relax the hazard by one write.
module wb_regfile
    import wb_regfile_pkg::*;
(
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic [WB_W-1:0]   Wb_bundle,
    input  logic [ADDR_W-1:0] Rd_addr_a,
    input  logic [ADDR_W-1:0] Rd_addr_b,
    input  logic              Use_a,
    input  logic              Use_b,
    output logic [DATA_W-1:0] Rd_data_a,
    output logic [DATA_W-1:0] Rd_data_b,
    input  logic              Issue_valid,
    input  logic [ADDR_W-1:0] Issue_rd,
    output logic              Stall,
    output logic              Err
);

    wb_bundle_t        wb_s;
    logic [DATA_W-1:0] reg_q [NREGS];
    logic [DATA_W-1:0] reg_d [NREGS];
    logic              byp_hit_a_s;
    logic              byp_hit_b_s;
    logic              hz_a_s;
    logic              hz_b_s;

    assign wb_s = wb_unpack(Wb_bundle);

`ifdef WB_BYPASS_EN
    assign byp_hit_a_s = wb_s.we & (wb_s.addr == Rd_addr_a);
    assign byp_hit_b_s = wb_s.we & (wb_s.addr == Rd_addr_b);
`else
    assign byp_hit_a_s = 1'b0;
    assign byp_hit_b_s = 1'b0;
`endif

    // Commit next-state
    always_comb begin
        reg_d = reg_q;
        if (wb_s.we) begin
            reg_d[wb_s.addr] = wb_s.data;
        end else begin
            reg_d = reg_q;
        end
    end

    // Register array
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                reg_q[r] <= '0;
            end
        end else begin
            reg_q <= reg_d;
        end
    end

    // Read muxing; outputs forced to zero while reset is held so a stray bundle cannot leak through.
    always_comb begin
        if (!Rst_n) begin
            Rd_data_a = '0;
            Rd_data_b = '0;
        end else begin
            Rd_data_a = byp_hit_a_s ? wb_s.data : reg_q[Rd_addr_a];
            Rd_data_b = byp_hit_b_s ? wb_s.data : reg_q[Rd_addr_b];
        end
    end

    wb_scoreboard u_scoreboard (
        .clk         (Clk),
        .rst_n       (Rst_n),
        .issue_valid (Issue_valid),
        .issue_rd    (Issue_rd),
        .dec_valid   (wb_s.we),
        .dec_addr    (wb_s.addr),
        .rd_addr_a   (Rd_addr_a),
        .rd_addr_b   (Rd_addr_b),
        .use_a       (Use_a),
        .use_b       (Use_b),
        .byp_hit_a   (byp_hit_a_s),
        .byp_hit_b   (byp_hit_b_s),
        .hz_a        (hz_a_s),
        .hz_b        (hz_b_s),
        .err         (Err)
    );

    assign Stall = hz_a_s | hz_b_s;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios plus randomized traffic
// checked against an array/counter reference model. Honours WB_BYPASS_EN.
`timescale 1ns/100ps
module tb_wb_regfile;

`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic [11:0] Wb_bundle = 12'h000;
    logic [2:0]  Rd_addr_a = 3'd0;
    logic [2:0]  Rd_addr_b = 3'd0;
    logic        Use_a = 1'b0;
    logic        Use_b = 1'b0;
    logic [7:0]  Rd_data_a;
    logic [7:0]  Rd_data_b;
    logic        Issue_valid = 1'b0;
    logic [2:0]  Issue_rd = 3'd0;
    logic        Stall;
    logic        Err;

    int n_tests = 0;
    int n_fail  = 0;

    wb_regfile dut (
        .Clk         (Clk),
        .Rst_n       (Rst_n),
        .Wb_bundle   (Wb_bundle),
        .Rd_addr_a   (Rd_addr_a),
        .Rd_addr_b   (Rd_addr_b),
        .Use_a       (Use_a),
        .Use_b       (Use_b),
        .Rd_data_a   (Rd_data_a),
        .Rd_data_b   (Rd_data_b),
        .Issue_valid (Issue_valid),
        .Issue_rd    (Issue_rd),
        .Stall       (Stall),
        .Err         (Err)
    );

    always #5 Clk = ~Clk;

    // Reference model: plain arrays of values and pending counts
    logic [7:0] m_reg [8];
    int         m_pend [8];
    logic       m_err;
    logic       m_stall;
    logic [7:0] m_rd_a;
    logic [7:0] m_rd_b;
    logic       wb_we;
    logic [2:0] wb_addr;
    logic [7:0] wb_data;

    assign wb_we   = Wb_bundle[0];
    assign wb_addr = Wb_bundle[3:1];
    assign wb_data = Wb_bundle[11:4];

    always_comb begin
        m_stall = (Use_a && (m_pend[Rd_addr_a] > ((BYP && wb_we && wb_addr == Rd_addr_a) ? 1 : 0)))
               || (Use_b && (m_pend[Rd_addr_b] > ((BYP && wb_we && wb_addr == Rd_addr_b) ? 1 : 0)));
        if (!Rst_n) begin
            m_rd_a = 8'h00;
            m_rd_b = 8'h00;
        end else begin
            m_rd_a = (BYP && wb_we && wb_addr == Rd_addr_a) ? wb_data : m_reg[Rd_addr_a];
            m_rd_b = (BYP && wb_we && wb_addr == Rd_addr_b) ? wb_data : m_reg[Rd_addr_b];
        end
    end

    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < 8; i++) begin
                m_reg[i]  <= 8'h00;
                m_pend[i] <= 0;
            end
            m_err <= 1'b0;
        end else begin
            if (wb_we) m_reg[wb_addr] <= wb_data;
            for (int r = 0; r < 8; r++) begin
                if ((Issue_valid && !m_stall && Issue_rd == r) && !(wb_we && wb_addr == r)) begin
                    if (m_pend[r] == 3) m_err <= 1'b1;
                    else m_pend[r] <= m_pend[r] + 1;
                end else if ((wb_we && wb_addr == r) && !(Issue_valid && !m_stall && Issue_rd == r)) begin
                    if (m_pend[r] == 0) m_err <= 1'b1;
                    else m_pend[r] <= m_pend[r] - 1;
                end
            end
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs();
        Wb_bundle = 12'h000; Issue_valid = 1'b0; Issue_rd = 3'd0;
        Use_a = 1'b0; Use_b = 1'b0; Rd_addr_a = 3'd0; Rd_addr_b = 3'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        Rst_n = 1'b0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            Rd_addr_a = 3'(i);
            Rd_addr_b = 3'(7 - i);
            #1;
            n_tests++;
            if (Rd_data_a !== 8'h00 || Rd_data_b !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_read r%0d: got a=%h b=%h expected 00", i, Rd_data_a, Rd_data_b);
            end
        end
        n_tests++;
        if (Stall !== 1'b0 || Err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got stall=%b err=%b expected 0 0", Stall, Err);
        end
        step();
    endtask

    task automatic test_commit();
        Issue_valid = 1'b1; Issue_rd = 3'd2;
        step();
        Issue_valid = 1'b0;
        Wb_bundle = {8'hA5, 3'd2, 1'b1};
        step();
        Wb_bundle = 12'h000; Rd_addr_a = 3'd2;
        #2;
        n_tests++;
        if (Rd_data_a !== 8'hA5) begin
            n_fail++;
            $display("FAIL commit_r2: got %h expected a5", Rd_data_a);
        end
        Wb_bundle = {8'hFF, 3'd2, 1'b0};
        step();
        Wb_bundle = 12'h000;
        #2;
        n_tests++;
        if (Rd_data_a !== 8'hA5 || Err !== 1'b0) begin
            n_fail++;
            $display("FAIL commit_we0: got data=%h err=%b expected a5 0", Rd_data_a, Err);
        end
        step();
    endtask

    task automatic test_hazard();
        Issue_valid = 1'b1; Issue_rd = 3'd3;
        step();
        Issue_valid = 1'b0; Use_a = 1'b1; Rd_addr_a = 3'd3;
        for (int c = 0; c < 2; c++) begin
            #2;
            n_tests++;
            if (Stall !== 1'b1) begin
                n_fail++;
                $display("FAIL hazard_wait c%0d: got stall=%b expected 1", c, Stall);
            end
            step();
        end
        Wb_bundle = {8'h3C, 3'd3, 1'b1};
        #2;
        n_tests++;
        if (BYP) begin
            if (Stall !== 1'b0 || Rd_data_a !== 8'h3C) begin
                n_fail++;
                $display("FAIL hazard_bypass: got stall=%b data=%h expected 0 3c", Stall, Rd_data_a);
            end
        end else begin
            if (Stall !== 1'b1) begin
                n_fail++;
                $display("FAIL hazard_wb_cycle: got stall=%b expected 1", Stall);
            end
        end
        step();
        Wb_bundle = 12'h000;
        #2;
        n_tests++;
        if (Stall !== 1'b0 || Rd_data_a !== 8'h3C) begin
            n_fail++;
            $display("FAIL hazard_release: got stall=%b data=%h expected 0 3c", Stall, Rd_data_a);
        end
        Use_a = 1'b0;
        step();
    endtask

    task automatic test_overflow();
        Issue_rd = 3'd5;
        for (int k = 0; k < 3; k++) begin
            Issue_valid = 1'b1;
            step();
        end
        #2;
        n_tests++;
        if (Err !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_before: got err=%b expected 0", Err);
        end
        step();
        Issue_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            Wb_bundle = {8'(8'h50 + k), 3'd5, 1'b1};
            step();
            Wb_bundle = 12'h000;
            #2;
            n_tests++;
            if (Err !== 1'b1) begin
                n_fail++;
                $display("FAIL ovf_sticky k%0d: got err=%b expected 1", k, Err);
            end
            Use_a = 1'b1; Rd_addr_a = 3'd5;
            #1;
            n_tests++;
            if (Stall !== (k < 2)) begin
                n_fail++;
                $display("FAIL ovf_drain k%0d: got stall=%b expected %b", k, Stall, (k < 2));
            end
            Use_a = 1'b0;
        end
        n_tests++;
        if (Rd_data_a !== 8'h52) begin
            n_fail++;
            $display("FAIL ovf_data: got %h expected 52", Rd_data_a);
        end
        step();
    endtask

    task automatic test_async_reset();
        Issue_valid = 1'b1; Issue_rd = 3'd1;
        step();
        Issue_valid = 1'b0; Use_a = 1'b1; Rd_addr_a = 3'd1;
        #2;
        n_tests++;
        if (Stall !== 1'b1) begin
            n_fail++;
            $display("FAIL arst_pre: got stall=%b expected 1", Stall);
        end
        Rst_n = 1'b0;
        #1;
        n_tests++;
        if (Stall !== 1'b0 || Err !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_immediate: got stall=%b err=%b expected 0 0", Stall, Err);
        end
        Rd_addr_a = 3'd5;
        Rst_n = 1'b1;
        #0.5;
        n_tests++;
        if (Rd_data_a !== 8'h00) begin
            n_fail++;
            $display("FAIL arst_regs: got r5=%h expected 00", Rd_data_a);
        end
        Use_a = 1'b0;
        step();
    endtask

    task automatic test_same_cycle();
        Issue_valid = 1'b1; Issue_rd = 3'd4;
        step();
        Wb_bundle = {8'h5A, 3'd4, 1'b1};
        step();
        Issue_valid = 1'b0; Wb_bundle = 12'h000; Use_a = 1'b1; Rd_addr_a = 3'd4;
        #2;
        n_tests++;
        if (Rd_data_a !== 8'h5A || Stall !== 1'b1 || Err !== 1'b0) begin
            n_fail++;
            $display("FAIL same_cycle_r4: got data=%h stall=%b err=%b expected 5a 1 0", Rd_data_a, Stall, Err);
        end
        Use_a = 1'b0;
        Wb_bundle = {8'h77, 3'd6, 1'b1};
        step();
        Wb_bundle = 12'h000; Rd_addr_b = 3'd6;
        #2;
        n_tests++;
        if (Err !== 1'b1 || Rd_data_b !== 8'h77) begin
            n_fail++;
            $display("FAIL underflow_r6: got err=%b data=%h expected 1 77", Err, Rd_data_b);
        end
        step();
    endtask

    task automatic test_random();
        int cand [$];
        do_reset();
        for (int c = 0; c < 400; c++) begin
            cand.delete();
            for (int r = 0; r < 8; r++) if (m_pend[r] > 0) cand.push_back(r);
            Issue_valid = ($urandom_range(0, 2) == 0);
            Issue_rd    = 3'($urandom_range(0, 7));
            Use_a       = 1'($urandom_range(0, 1));
            Use_b       = 1'($urandom_range(0, 1));
            Rd_addr_a   = 3'($urandom_range(0, 7));
            Rd_addr_b   = 3'($urandom_range(0, 7));
            if (cand.size() > 0 && $urandom_range(0, 1) == 1)
                Wb_bundle = {8'($urandom), 3'(cand[$urandom_range(0, cand.size() - 1)]), 1'b1};
            else if ($urandom_range(0, 99) == 0)
                Wb_bundle = {8'($urandom), 3'($urandom_range(0, 7)), 1'b1};
            else
                Wb_bundle = {8'($urandom), 3'($urandom_range(0, 7)), 1'b0};
            #2;
            n_tests++;
            if (Stall !== m_stall || Rd_data_a !== m_rd_a || Rd_data_b !== m_rd_b || Err !== m_err) begin
                n_fail++;
                $display("FAIL random c%0d: got stall=%b a=%h b=%h err=%b expected %b %h %h %b",
                         c, Stall, Rd_data_a, Rd_data_b, Err, m_stall, m_rd_a, m_rd_b, m_err);
            end
            step();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_commit();
        test_hazard();
        test_overflow();
        test_async_reset();
        test_same_cycle();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
